alarm_controller: RTL and testbench

//  Sequential arming/alarm controller placed directly downstream of the 8-zone priority encoder.

---
 rtl/alarm_controller.sv | 136 +++++++++++++
 tb/tb_alarm_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Arming/alarm controller fed by the 8-zone priority encoder.
// Optional ALARM_LOG_EN macro builds the saturating alarm event counter.
module alarm_controller #(
    parameter int EXIT_TICKS  = 10,
    parameter int ENTRY_TICKS = 8,
    parameter int SIREN_TICKS = 20,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       arm,
    input  logic       disarm,
    input  logic [2:0] intruder_zone,
    input  logic       valid,
    output logic [2:0] state,
    output logic       armed,
    output logic       siren,
    output logic [2:0] alarm_zone,
    output logic       alarm_mem,
    output logic [7:0] alarm_count
);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_ENTRY    = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] EXIT_N  = CNT_W'(EXIT_TICKS);
    localparam logic [CNT_W-1:0] ENTRY_N = CNT_W'(ENTRY_TICKS);
    localparam logic [CNT_W-1:0] SIREN_N = CNT_W'(SIREN_TICKS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           st;
    logic [CNT_W-1:0] timer;
    logic             expire;
    logic             zone_hot;

    // A dwell ends on the tick that finds the timer at 1.
    assign expire   = tick && (timer == ONE);
    // Any zone other than the entry door trips the alarm at once.
    assign zone_hot = valid && (intruder_zone != 3'd0);

    // Main FSM: disarm overrides everything, zone events beat timer expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_DISARMED;
            timer      <= '0;
            alarm_zone <= 3'd0;
            alarm_mem  <= 1'b0;
        end else if (disarm) begin
            st         <= S_DISARMED;
            timer      <= '0;
            alarm_zone <= 3'd0;
            alarm_mem  <= 1'b0;
        end else begin
            case (st)
                S_DISARMED: begin
                    if (arm) begin
                        st    <= S_EXIT;
                        timer <= EXIT_N;
                    end
                end
                S_EXIT: begin
                    if (expire) begin
                        st    <= S_ARMED;
                        timer <= '0;
                    end else if (tick) begin
                        timer <= timer - ONE;
                    end
                end
                S_ARMED: begin
                    if (valid) begin
                        // First cause is kept until disarm.
                        if (!alarm_mem) alarm_zone <= intruder_zone;
                        alarm_mem <= 1'b1;
                        if (intruder_zone == 3'd0) begin
                            st    <= S_ENTRY;
                            timer <= ENTRY_N;
                        end else begin
                            st    <= S_ALARM;
                            timer <= SIREN_N;
                        end
                    end
                end
                S_ENTRY: begin
                    if (zone_hot || expire) begin
                        st    <= S_ALARM;
                        timer <= SIREN_N;
                    end else if (tick) begin
                        timer <= timer - ONE;
                    end
                end
                S_ALARM: begin
                    if (expire) begin
                        st    <= S_ARMED;
                        timer <= '0;
                    end else if (tick) begin
                        timer <= timer - ONE;
                    end
                end
                default: begin
                    st    <= S_DISARMED;
                    timer <= '0;
                end
            endcase
        end
    end

    assign state = st;
    assign armed = (st == S_ARMED) || (st == S_ENTRY) || (st == S_ALARM);
    assign siren = (st == S_ALARM);

`ifdef ALARM_LOG_EN
    logic enter_alarm;

    assign enter_alarm = !disarm &&
        (((st == S_ARMED) && zone_hot) ||
         ((st == S_ENTRY) && (zone_hot || expire)));

    // Saturating count of ALARM entries; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_count <= 8'd0;
        end else if (enter_alarm && (alarm_count != 8'hFF)) begin
            alarm_count <= alarm_count + 8'd1;
        end
    end
`else
    assign alarm_count = 8'd0;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller (EXIT=3, ENTRY=2, SIREN=4).
// Expected values are pushed by the stimulus and checked by a monitor.
module tb_alarm_controller;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       arm;
    logic       disarm;
    logic [2:0] intruder_zone;
    logic       valid;
    logic [2:0] state;
    logic       armed;
    logic       siren;
    logic [2:0] alarm_zone;
    logic       alarm_mem;
    logic [7:0] alarm_count;

`ifdef ALARM_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    typedef struct {
        logic [2:0] st;
        logic       arm;
        logic       sir;
        logic [2:0] zone;
        logic       mem;
        logic [7:0] cnt;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    passed = 0;
    int    total  = 0;
    bit    slow   = 1'b0;
    int    ph     = 0;
    int    ac     = 0;

    alarm_controller #(
        .EXIT_TICKS (3),
        .ENTRY_TICKS(2),
        .SIREN_TICKS(4),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .arm          (arm),
        .disarm       (disarm),
        .intruder_zone(intruder_zone),
        .valid        (valid),
        .state        (state),
        .armed        (armed),
        .siren        (siren),
        .alarm_zone   (alarm_zone),
        .alarm_mem    (alarm_mem),
        .alarm_count  (alarm_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t  e;
            string n;
            e = q.pop_front();
            n = qn.pop_front();
            total = total + 1;
            if (state === e.st && armed === e.arm && siren === e.sir &&
                alarm_zone === e.zone && alarm_mem === e.mem &&
                alarm_count === e.cnt) begin
                passed = passed + 1;
            end else begin
                $display("FAIL %s: got st=%0d arm=%0b sir=%0b z=%0d m=%0b c=%0d want st=%0d arm=%0b sir=%0b z=%0d m=%0b c=%0d",
                    n, state, armed, siren, alarm_zone, alarm_mem, alarm_count,
                    e.st, e.arm, e.sir, e.zone, e.mem, e.cnt);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (slow) begin
            ph   = ph + 1;
            tick = (ph % 4 == 0);
        end else begin
            tick = 1'b1;
        end
    endtask

    task automatic chk(input string n, input int st, input bit a,
                       input bit s, input int z, input bit m);
        exp_t e;
        e.st   = 3'(st);
        e.arm  = a;
        e.sir  = s;
        e.zone = 3'(z);
        e.mem  = m;
        e.cnt  = LOG ? 8'(ac) : 8'd0;
        q.push_back(e);
        qn.push_back(n);
    endtask

    task automatic trip(input int z);
        valid = 1'b1;
        intruder_zone = 3'(z);
        cyc();
        valid = 1'b0;
        intruder_zone = 3'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        tick = 1'b1;
        arm = 1'b0;
        disarm = 1'b0;
        valid = 1'b0;
        intruder_zone = 3'd0;
        cyc();
        chk("reset", 0, 0, 0, 0, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("idle", 0, 0, 0, 0, 0);

        // Arm; zone activity during exit delay is ignored.
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        valid = 1'b1;
        intruder_zone = 3'd5;
        chk("exit1", 1, 0, 0, 0, 0);
        cyc();
        valid = 1'b0;
        chk("exit2", 1, 0, 0, 0, 0);
        cyc();
        chk("exit3", 1, 0, 0, 0, 0);
        cyc();
        chk("armed", 2, 1, 0, 0, 0);

        // Immediate alarm on zone code 5, siren for 4 cycles.
        trip(5);
        ac = ac + 1;
        for (int i = 0; i < 4; i++) begin
            chk("siren_on", 4, 1, 1, 5, 1);
            cyc();
        end
        chk("rearm", 2, 1, 0, 5, 1);

        // Entry delay, disarmed early.
        trip(0);
        chk("entry_a", 3, 1, 0, 5, 1);
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
        chk("disarm_entry", 0, 0, 0, 0, 0);

        arm = 1'b1;
        cyc();
        arm = 1'b0;
        repeat (3) cyc();
        chk("armed2", 2, 1, 0, 0, 0);

        // Entry delay runs out into ALARM.
        trip(0);
        chk("entry_b1", 3, 1, 0, 0, 1);
        cyc();
        chk("entry_b2", 3, 1, 0, 0, 1);
        cyc();
        ac = ac + 1;
        chk("entry_alarm", 4, 1, 1, 0, 1);
        repeat (3) cyc();
        chk("entry_alarm4", 4, 1, 1, 0, 1);
        cyc();
        chk("rearm2", 2, 1, 0, 0, 1);

        // Fresh arm, entry then non-door zone: immediate alarm, zone 0 kept.
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
        chk("disarm2", 0, 0, 0, 0, 0);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        repeat (3) cyc();
        chk("armed3", 2, 1, 0, 0, 0);
        trip(0);
        chk("entry_c", 3, 1, 0, 0, 1);
        trip(3);
        ac = ac + 1;
        chk("entry_trip", 4, 1, 1, 0, 1);
        repeat (4) cyc();
        chk("rearm3", 2, 1, 0, 0, 1);
        trip(6);
        ac = ac + 1;
        chk("second_trip", 4, 1, 1, 0, 1);
        repeat (4) cyc();
        chk("rearm4", 2, 1, 0, 0, 1);

        // Arm and disarm together stay disarmed.
        disarm = 1'b1;
        cyc();
        chk("disarm3", 0, 0, 0, 0, 0);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        disarm = 1'b0;
        chk("arm_and_disarm", 0, 0, 0, 0, 0);

        // Slow timebase: tick every 4th cycle gives a 12-cycle exit dwell.
        slow = 1'b1;
        ph = 0;
        tick = 1'b0;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("slow_exit", 1, 0, 0, 0, 0);
            cyc();
        end
        chk("slow_armed", 2, 1, 0, 0, 0);
        slow = 1'b0;
        tick = 1'b1;

        // Disarm mid-ALARM drops the siren on the next edge.
        trip(2);
        ac = ac + 1;
        chk("alarm_z2", 4, 1, 1, 2, 1);
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
        chk("disarm_alarm", 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of ALARM.
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        repeat (3) cyc();
        chk("armed4", 2, 1, 0, 0, 0);
        trip(7);
        ac = ac + 1;
        chk("alarm_z7", 4, 1, 1, 7, 1);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        ac = 0;
        chk("async_reset", 0, 0, 0, 0, 0);
        cyc();
        rst_n = 1'b1;

        // 300 alarms: counter saturates at 255.
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        repeat (3) cyc();
        for (int i = 1; i <= 300; i++) begin
            trip(1);
            if (ac < 255) ac = ac + 1;
            repeat (4) cyc();
            if (i == 254 || i == 255 || i == 300) chk("count_sat", 2, 1, 0, 1, 1);
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            total = total + 1;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
